// File: rtl/reg_writeback_queue.sv
// Writeback queue merging memory-stage (B) and execute-stage (A) results into
// the register file / PC in program order, with youngest-value forwarding.
module reg_writeback_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       b_valid,
  input  logic [3:0]                 b_dest,
  input  logic [WIDTH-1:0]           b_data,
  output logic                       b_ready,
  input  logic                       a_valid,
  input  logic [3:0]                 a_dest,
  input  logic [WIDTH-1:0]           a_data,
  output logic                       a_ready,
  output logic                       wr_enable,
  output logic [3:0]                 wr_dest,
  output logic [WIDTH-1:0]           wr_data,
  output logic                       pc_load,
  output logic [WIDTH-1:0]           pc_value,
  input  logic [3:0]                 src_0,
  input  logic [3:0]                 src_1,
  output logic                       fwd_hit_0,
  output logic                       fwd_hit_1,
  output logic [WIDTH-1:0]           fwd_data_0,
  output logic [WIDTH-1:0]           fwd_data_1,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       hold
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] PC_REG = 4'd15;

  logic [3:0]       r_dest [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic [CW-1:0]    w_free;
  logic             w_not_empty;
  logic             w_push_b;
  logic             w_push_a;
  logic             w_pop;
  logic [AW-1:0]    w_a_slot;
  logic [3:0]       w_head_dest;
  logic [WIDTH-1:0] w_head_data;

  // Space comes only from the registered count, so a same-cycle pop never frees a slot.
  assign w_free      = CW'(DEPTH) - r_count;
  assign w_not_empty = (r_count != '0);

  // Readies are gated by reset because an empty queue would otherwise report space.
  assign b_ready  = reset && (w_free != '0);
  assign a_ready  = reset && ((w_free >= CW'(2)) || ((w_free == CW'(1)) && !b_valid));

  assign w_push_b = b_valid && b_ready;
  assign w_push_a = a_valid && a_ready;
  assign w_pop    = w_not_empty && !hold;
  assign w_a_slot = r_wr_ptr + AW'(w_push_b);

  assign w_head_dest = r_dest[r_rd_ptr];
  assign w_head_data = r_data[r_rd_ptr];

  assign wr_enable = w_pop && (w_head_dest != PC_REG);
  assign pc_load   = w_pop && (w_head_dest == PC_REG);
  assign wr_dest   = w_not_empty ? w_head_dest : '0;
  assign wr_data   = w_not_empty ? w_head_data : '0;
  assign pc_value  = w_not_empty ? w_head_data : '0;
  assign count     = r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_wr_ptr <= r_wr_ptr + AW'(w_push_b) + AW'(w_push_a);
      r_count  <= r_count + CW'(w_push_b) + CW'(w_push_a) - CW'(w_pop);
    end
  end

  // NOTE: entry storage is not reset; occupancy is defined solely by count, so stale slots are never observed.
  always_ff @(posedge clk) begin
    if (w_push_b) begin
      r_dest[r_wr_ptr] <= b_dest;
      r_data[r_wr_ptr] <= b_data;
    end
    if (w_push_a) begin
      r_dest[w_a_slot] <= a_dest;
      r_data[w_a_slot] <= a_data;
    end
  end

  // Scan oldest to youngest so the last match left in res is the youngest pending value.
  function automatic logic [WIDTH:0] fwd_lookup(input logic [3:0] src);
    logic [WIDTH:0] res;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (src != PC_REG) && (r_dest[r_rd_ptr + AW'(i)] == src)) begin
        res = {1'b1, r_data[r_rd_ptr + AW'(i)]};
      end
    end
    return res;
  endfunction

  // NOTE: each always_comb output is fully assigned on every path, so no latch is inferred.
  always_comb begin
    {fwd_hit_0, fwd_data_0} = fwd_lookup(src_0);
    {fwd_hit_1, fwd_data_1} = fwd_lookup(src_1);
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             b_valid, a_valid, hold;
  logic [3:0]       b_dest, a_dest, src_0, src_1;
  logic [WIDTH-1:0] b_data, a_data;
  logic             b_ready, a_ready, wr_enable, pc_load, fwd_hit_0, fwd_hit_1;
  logic [3:0]       wr_dest;
  logic [WIDTH-1:0] wr_data, pc_value, fwd_data_0, fwd_data_1;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]       dest;
    logic [WIDTH-1:0] data;
  } entry_t;
  entry_t q[$];

  reg_writeback_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
    .wr_enable(wr_enable), .wr_dest(wr_dest), .wr_data(wr_data),
    .pc_load(pc_load), .pc_value(pc_value),
    .src_0(src_0), .src_1(src_1),
    .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
    .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1),
    .count(count), .hold(hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Youngest matching pending value; register 15 is never forwarded.
  function automatic logic [WIDTH:0] model_fwd(input logic [3:0] s);
    logic [WIDTH:0] r;
    r = '0;
    if (s != 4'd15)
      foreach (q[i]) if (q[i].dest == s) r = {1'b1, q[i].data};
    return r;
  endfunction

  task automatic drive(input logic bv, input logic [3:0] bd, input logic [WIDTH-1:0] bx,
                       input logic av, input logic [3:0] ad, input logic [WIDTH-1:0] ax,
                       input logic h, input logic [3:0] s0, input logic [3:0] s1);
    b_valid = bv; b_dest = bd; b_data = bx;
    a_valid = av; a_dest = ad; a_data = ax;
    hold = h; src_0 = s0; src_1 = s1;
  endtask

  // One clock: drive, check every output against the model, then advance the model.
  task automatic step(input logic bv, input logic [3:0] bd, input logic [WIDTH-1:0] bx,
                      input logic av, input logic [3:0] ad, input logic [WIDTH-1:0] ax,
                      input logic h, input logic [3:0] s0, input logic [3:0] s1);
    int free;
    logic exp_br, exp_ar, exp_we, exp_pc;
    logic [3:0] exp_wd;
    logic [WIDTH-1:0] exp_wx;
    logic [WIDTH:0] f0, f1;
    @(negedge clk);
    drive(bv, bd, bx, av, ad, ax, h, s0, s1);
    #1;
    free   = DEPTH - q.size();
    exp_br = (free >= 1);
    exp_ar = (free >= 2) || (free == 1 && !bv);
    exp_we = 1'b0; exp_pc = 1'b0; exp_wd = '0; exp_wx = '0;
    if (q.size() > 0) begin
      exp_wd = q[0].dest;
      exp_wx = q[0].data;
      exp_we = !h && (q[0].dest != 4'd15);
      exp_pc = !h && (q[0].dest == 4'd15);
    end
    f0 = model_fwd(s0);
    f1 = model_fwd(s1);
    check("count",      WIDTH'(count),      WIDTH'(q.size()));
    check("b_ready",    WIDTH'(b_ready),    WIDTH'(exp_br));
    check("a_ready",    WIDTH'(a_ready),    WIDTH'(exp_ar));
    check("wr_enable",  WIDTH'(wr_enable),  WIDTH'(exp_we));
    check("wr_dest",    WIDTH'(wr_dest),    WIDTH'(exp_wd));
    check("wr_data",    wr_data,            exp_wx);
    check("pc_load",    WIDTH'(pc_load),    WIDTH'(exp_pc));
    check("pc_value",   pc_value,           exp_wx);
    check("fwd_hit_0",  WIDTH'(fwd_hit_0),  WIDTH'(f0[WIDTH]));
    check("fwd_data_0", fwd_data_0,         f0[WIDTH-1:0]);
    check("fwd_hit_1",  WIDTH'(fwd_hit_1),  WIDTH'(f1[WIDTH]));
    check("fwd_data_1", fwd_data_1,         f1[WIDTH-1:0]);
    @(posedge clk);
    if (q.size() > 0 && !h) void'(q.pop_front());
    if (bv && exp_br) q.push_back('{dest: bd, data: bx});
    if (av && exp_ar) q.push_back('{dest: ad, data: ax});
  endtask

  task automatic idle_step(input logic h);
    step(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, h, 4'd0, 4'd0);
  endtask

  // Just after an edge: park inputs idle so head/forward outputs can be checked literally.
  task automatic peek(input logic h, input logic [3:0] s0);
    #1;
    drive(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, h, s0, 4'd0);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_b_ready",   WIDTH'(b_ready),   '0);
    check("rst_a_ready",   WIDTH'(a_ready),   '0);
    check("rst_count",     WIDTH'(count),     '0);
    check("rst_wr_enable", WIDTH'(wr_enable), '0);
    check("rst_pc_load",   WIDTH'(pc_load),   '0);
    check("rst_wr_data",   wr_data,           '0);
    check("rst_fwd_hit_0", WIDTH'(fwd_hit_0), '0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_b_ready",   WIDTH'(b_ready),   WIDTH'(1));
    check("rel_a_ready",   WIDTH'(a_ready),   WIDTH'(1));
    check("rel_count",     WIDTH'(count),     '0);
    check("rel_wr_enable", WIDTH'(wr_enable), '0);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
    do_reset();

    // Single push reaches the head one edge later, then commits.
    step(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
    peek(1'b0, 4'd3);
    check("single_we",   WIDTH'(wr_enable), WIDTH'(1));
    check("single_dest", WIDTH'(wr_dest),   WIDTH'(3));
    check("single_data", wr_data,           32'hDEADBEEF);
    idle_step(1'b0);
    peek(1'b0, 4'd0);
    check("single_drained", WIDTH'(count), '0);

    // Dual push under hold: B before A, forwarding returns the younger A value.
    step(1'b1, 4'd1, 32'h11, 1'b1, 4'd1, 32'h22, 1'b1, 4'd1, 4'd0);
    peek(1'b1, 4'd1);
    check("dual_count", WIDTH'(count),     WIDTH'(2));
    check("dual_hit",   WIDTH'(fwd_hit_0), WIDTH'(1));
    check("dual_fwd",   fwd_data_0,        32'h22);
    idle_step(1'b0);
    peek(1'b0, 4'd0);
    check("dual_second", wr_data, 32'h22);
    idle_step(1'b0);

    // R15 goes to the PC, never to the register file or the forward path.
    step(1'b1, 4'd15, 32'h100, 1'b0, 4'd0, '0, 1'b0, 4'd0, 4'd0);
    peek(1'b0, 4'd15);
    check("pc_load",  WIDTH'(pc_load),   WIDTH'(1));
    check("pc_value", pc_value,          32'h100);
    check("pc_no_we", WIDTH'(wr_enable), '0);
    check("pc_nofwd", WIDTH'(fwd_hit_0), '0);
    idle_step(1'b0);

    // Fill to three under hold, then a dual offer with one free slot.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 4), 32'hA0 + i, 1'b0, 4'd0, '0, 1'b1, 4'd4, 4'd6);
    step(1'b1, 4'd7, 32'hB7, 1'b1, 4'd8, 32'hB8, 1'b1, 4'd7, 4'd8);
    peek(1'b1, 4'd7);
    check("full_count", WIDTH'(count), WIDTH'(4));
    drive(1'b1, 4'd9, 32'hC9, 1'b1, 4'd10, 32'hCA, 1'b0, 4'd7, 4'd8);
    #1;
    check("full_b_ready", WIDTH'(b_ready), '0);
    check("full_a_ready", WIDTH'(a_ready), '0);
    step(1'b1, 4'd9, 32'hC9, 1'b1, 4'd10, 32'hCA, 1'b0, 4'd7, 4'd8);
    for (int i = 0; i < 5; i++) idle_step(1'b0);

    // Ten single pushes with hold toggling exercise pointer wrap.
    for (int i = 0; i < 10; i++)
      step(1'b1, 4'(i + 2), 32'h1000 + i, 1'b0, 4'd0, '0, 1'(i % 2), 4'(i + 1), 4'(i));
    for (int i = 0; i < 12; i++) idle_step(1'b0);

    // Reset mid-drain with three entries pending.
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), 32'hE0 + i, 1'b0, 4'd0, '0, 1'b1, 4'd2, 4'd3);
    step(1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, 4'd3, 4'd4);
    peek(1'b0, 4'd3);
    check("pre_rst_count", WIDTH'(count), WIDTH'(3));
    do_reset();
    for (int i = 0; i < 3; i++) idle_step(1'b0);
    step(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66, 1'b0, 4'd5, 4'd6);
    idle_step(1'b0);
    idle_step(1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] bd, ad;
      bd = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      ad = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      step(1'($urandom_range(0, 99) < 60), bd, $urandom,
           1'($urandom_range(0, 99) < 60), ad, $urandom,
           1'($urandom_range(0, 99) < 30),
           4'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5)));
    end
    for (int i = 0; i < 6; i++) idle_step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
